tpu_seq_ctrl: RTL and testbench

Sequencer for a DIM×DIM systolic array of signed MAC cells, one `tpumac` per cell. One `start` runs a fixed schedule: optionally clear the accumulators one row at a time, stream DIM skew-fed A/B input steps, flush the pipeline, then present each accumulator row for readout. The block sits between the host/memory interface and the array. It drives the per-row enable and write-enable lines, the input-step index and the readout row index; it carries no datapath.

---
 rtl/tpu_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_tpu_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_seq_ctrl.sv
// Schedule sequencer for a DIM x DIM systolic MAC array: optional per-row accumulator
// clear, skewed input feed, pipeline flush, then row-by-row readout of the results.
module tpu_seq_ctrl #(
    parameter  int unsigned DIM = 4,
    localparam int unsigned IW  = $clog2(DIM)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_clr_c,
    input  logic           i_stall,
    output logic           o_busy,
    output logic           o_done,
    output logic [DIM-1:0] o_mac_en_row,
    output logic [DIM-1:0] o_mac_wren_row,
    output logic           o_c_zero,
    output logic           o_feed_vld,
    output logic [IW-1:0]  o_feed_idx,
    output logic           o_rd_vld,
    output logic [IW-1:0]  o_rd_row
);

    localparam int unsigned CW = $clog2(2 * DIM - 1);

    localparam logic [CW-1:0] LastRow   = CW'(DIM - 1);
    localparam logic [CW-1:0] LastFlush = CW'(2 * DIM - 3);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StFlush,
        StRead
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            w_last;
    logic [DIM-1:0]  w_row_onehot;

    assign w_row_onehot = {{(DIM - 1){1'b0}}, 1'b1} << r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next state: every active state exits on its own terminal count; stall freezes all.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_last      = 1'b0;

        unique case (r_state)
            StIdle:  w_last = 1'b0;
            StClear: w_last = (r_cnt == LastRow);
            StFeed:  w_last = (r_cnt == LastRow);
            StFlush: w_last = (r_cnt == LastFlush);
            StRead:  w_last = (r_cnt == LastRow);
            default: w_last = 1'b0;
        endcase

        if (r_state == StIdle) begin
            if (i_start) begin
                w_state_nxt = i_clr_c ? StClear : StFeed;
                w_cnt_nxt   = '0;
            end
        end else if (!i_stall) begin
            if (w_last) begin
                w_cnt_nxt = '0;
                unique case (r_state)
                    StClear: w_state_nxt = StFeed;
                    StFeed:  w_state_nxt = StFlush;
                    StFlush: w_state_nxt = StRead;
                    StRead: begin
                        w_state_nxt = StIdle;
                        w_done_nxt  = 1'b1;
                    end
                    default: w_state_nxt = StIdle;
                endcase
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // Enables and valids are gated by stall; selects and indices decode from state only.
    always_comb begin
        o_mac_en_row   = '0;
        o_mac_wren_row = '0;
        o_c_zero       = 1'b0;
        o_feed_vld     = 1'b0;
        o_feed_idx     = '0;
        o_rd_vld       = 1'b0;
        o_rd_row       = '0;

        unique case (r_state)
            StIdle: begin
                o_mac_en_row = '0;
            end
            StClear: begin
                o_c_zero = 1'b1;
                if (!i_stall) begin
                    o_mac_en_row   = w_row_onehot;
                    o_mac_wren_row = w_row_onehot;
                end
            end
            StFeed: begin
                o_feed_idx = r_cnt[IW-1:0];
                if (!i_stall) begin
                    o_mac_en_row = '1;
                    o_feed_vld   = 1'b1;
                end
            end
            StFlush: begin
                if (!i_stall) begin
                    o_mac_en_row = '1;
                end
            end
            StRead: begin
                o_rd_row = r_cnt[IW-1:0];
                if (!i_stall) begin
                    o_rd_vld = 1'b1;
                end
            end
            default: begin
                o_mac_en_row = '0;
            end
        endcase
    end

    assign o_busy = (r_state != StIdle);
    assign o_done = r_done;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Self-checking bench for tpu_seq_ctrl: per-cycle scoreboard driven from a schedule model,
// scenario table for the DIM=4 plan, plus reset-abort and DIM=2/8 latency sequences.
module tb_tpu_seq_ctrl;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       start = 1'b0, clr_c = 1'b0, stall = 1'b0;
    logic       busy, done, czero, fvld, rvld;
    logic [3:0] en, wren;
    logic [1:0] fidx, rrow;

    logic       start2 = 1'b0, clr2 = 1'b0, stall2 = 1'b0;
    logic       busy2, done2, czero2, fvld2, rvld2;
    logic [1:0] en2, wren2;
    logic [0:0] fidx2, rrow2;

    logic       start8 = 1'b0, clr8 = 1'b0, stall8 = 1'b0;
    logic       busy8, done8, czero8, fvld8, rvld8;
    logic [7:0] en8, wren8;
    logic [2:0] fidx8, rrow8;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tpu_seq_ctrl #(.DIM(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clr_c(clr_c), .i_stall(stall),
        .o_busy(busy), .o_done(done), .o_mac_en_row(en), .o_mac_wren_row(wren),
        .o_c_zero(czero), .o_feed_vld(fvld), .o_feed_idx(fidx), .o_rd_vld(rvld),
        .o_rd_row(rrow)
    );

    tpu_seq_ctrl #(.DIM(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_clr_c(clr2), .i_stall(stall2),
        .o_busy(busy2), .o_done(done2), .o_mac_en_row(en2), .o_mac_wren_row(wren2),
        .o_c_zero(czero2), .o_feed_vld(fvld2), .o_feed_idx(fidx2), .o_rd_vld(rvld2),
        .o_rd_row(rrow2)
    );

    tpu_seq_ctrl #(.DIM(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_clr_c(clr8), .i_stall(stall8),
        .o_busy(busy8), .o_done(done8), .o_mac_en_row(en8), .o_mac_wren_row(wren8),
        .o_c_zero(czero8), .o_feed_vld(fvld8), .o_feed_idx(fidx8), .o_rd_vld(rvld8),
        .o_rd_row(rrow8)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] en;
        logic [3:0] wren;
        logic       cz;
        logic       fv;
        logic [1:0] fi;
        logic       rv;
        logic [1:0] rr;
    } obs_t;

    typedef struct {
        obs_t e;
        bit   m_fi;
        bit   m_rr;
    } sb_t;

    // One scenario: clr_c at cycle 0, stall window, extra start pulses, expected done cycle.
    typedef struct {
        bit clr;
        int st_a;
        int st_b;
        int xs_a;
        int xs_b;
        int exp_done;
    } scn_t;

    sb_t  sbq[$];
    scn_t scn[8];

    function automatic obs_t sample4();
        obs_t o;
        o.busy = busy;  o.done = done;  o.en = en;   o.wren = wren;
        o.cz   = czero; o.fv   = fvld;  o.fi = fidx; o.rv   = rvld; o.rr = rrow;
        return o;
    endfunction

    // Expected outputs from the phase index ph (0..5D-3 over CLEAR/FEED/FLUSH/READ).
    function automatic obs_t model_out(input bit act, input int ph, input bit mdone,
                                       input bit stl);
        obs_t o;
        o = '0;
        if (!act) begin
            o.done = mdone;
            return o;
        end
        o.busy = 1'b1;
        if (ph < D) begin
            o.en   = 4'b0001 << ph;
            o.wren = o.en;
            o.cz   = 1'b1;
        end else if (ph < 2 * D) begin
            o.en = 4'b1111;
            o.fv = 1'b1;
            o.fi = 2'(ph - D);
        end else if (ph < 4 * D - 2) begin
            o.en = 4'b1111;
        end else begin
            o.rv = 1'b1;
            o.rr = 2'(ph - (4 * D - 2));
        end
        if (stl) begin
            o.en   = '0;
            o.wren = '0;
            o.fv   = 1'b0;
            o.rv   = 1'b0;
        end
        return o;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got busy%b done%b en%b wren%b cz%b fv%b fi%0d rv%b rr%0d, expected busy%b done%b en%b wren%b cz%b fv%b fi%0d rv%b rr%0d",
                     name, act.busy, act.done, act.en, act.wren, act.cz, act.fv, act.fi,
                     act.rv, act.rr, exp.busy, exp.done, exp.en, exp.wren, exp.cz, exp.fv,
                     exp.fi, exp.rv, exp.rr);
        end
    endtask

    task automatic run_scn(input int idx, input scn_t s);
        bit   mact, mdone, stl, st;
        int   ph, first_done;
        sb_t  e, q_e;
        obs_t a;
        mact = 1'b0; mdone = 1'b0; ph = 0; first_done = -1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            st    = (c == 0) || (c == s.xs_a) || (c == s.xs_b);
            stl   = (s.st_a >= 0) && (c >= s.st_a) && (c <= s.st_b);
            start = st;
            clr_c = (c == 0) ? s.clr : !s.clr;
            stall = stl;
            e.e    = model_out(mact, ph, mdone, stl);
            e.m_fi = !mact || (ph >= D && ph < 2 * D);
            e.m_rr = !mact || (ph >= 4 * D - 2);
            sbq.push_back(e);
            if (mact) begin
                if (!stl) begin
                    ph++;
                    if (ph == 5 * D - 2) begin
                        mact  = 1'b0;
                        mdone = 1'b1;
                    end
                end
            end else begin
                mdone = 1'b0;
                if (st) begin
                    mact = 1'b1;
                    ph   = clr_c ? 0 : D;
                end
            end
            @(negedge clk);
            a   = sample4();
            q_e = sbq.pop_front();
            if (!q_e.m_fi) a.fi = '0;
            if (!q_e.m_rr) a.rr = '0;
            check_obs($sformatf("scn%0d_cyc%0d", idx, c), a, q_e.e);
            if (a.done && first_done < 0) first_done = c;
        end
        start = 1'b0; clr_c = 1'b0; stall = 1'b0;
        check_int($sformatf("scn%0d_done_cycle", idx), first_done, s.exp_done);
    endtask

    task automatic run_lat(input int which, input bit clr, input int exp_lat);
        int lat, nbusy;
        bit b, d;
        lat = -1; nbusy = 0;
        for (int c = 0; c < 100 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (which == 2) begin
                start2 = (c == 0); clr2 = clr;
            end else begin
                start8 = (c == 0); clr8 = clr;
            end
            @(negedge clk);
            b = (which == 2) ? busy2 : busy8;
            d = (which == 2) ? done2 : done8;
            if (d) begin
                lat = c;
                check_int($sformatf("dim%0d_clr%0d_busy_at_done", which, clr), int'(b), 0);
            end else if (b) begin
                nbusy++;
            end
        end
        start2 = 1'b0; start8 = 1'b0;
        check_int($sformatf("dim%0d_clr%0d_latency", which, clr), lat, exp_lat);
        check_int($sformatf("dim%0d_clr%0d_busy_cycles", which, clr), nbusy, exp_lat - 1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        obs_t a, exp_o;
        int   nd;

        scn[0] = '{clr: 1'b1, st_a: -1, st_b: -1, xs_a: -1, xs_b: -1, exp_done: 19};
        scn[1] = '{clr: 1'b0, st_a: -1, st_b: -1, xs_a: -1, xs_b: -1, exp_done: 15};
        scn[2] = '{clr: 1'b1, st_a:  6, st_b:  7, xs_a: -1, xs_b: -1, exp_done: 21};
        scn[3] = '{clr: 1'b0, st_a: -1, st_b: -1, xs_a:  3, xs_b: 10, exp_done: 15};
        scn[4] = '{clr: 1'b0, st_a: -1, st_b: -1, xs_a: 15, xs_b: -1, exp_done: 15};
        scn[5] = '{clr: 1'b1, st_a:  2, st_b:  2, xs_a: -1, xs_b: -1, exp_done: 20};
        scn[6] = '{clr: 1'b0, st_a: 13, st_b: 13, xs_a: -1, xs_b: -1, exp_done: 16};
        scn[7] = '{clr: 1'b0, st_a:  6, st_b:  8, xs_a: -1, xs_b: -1, exp_done: 18};

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_obs("reset_outputs", sample4(), '0);
        check_int("reset_small_big", int'({busy2, done2, busy8, done8}), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            run_scn(i, scn[i]);
        end

        // Reset in FEED aborts the sequence without a done pulse.
        @(posedge clk); #1;
        start = 1'b1; clr_c = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        exp_o      = '0;
        exp_o.busy = 1'b1; exp_o.en = 4'b1111; exp_o.fv = 1'b1; exp_o.fi = 2'd2;
        check_obs("abort_pre_reset", sample4(), exp_o);
        #2 rst_n = 1'b0;
        #1 check_obs("abort_async_zero", sample4(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            a = sample4();
            if (a.done || a.busy) nd++;
        end
        check_int("abort_no_done_busy", nd, 0);
        run_scn(8, scn[0]);

        run_lat(2, 1'b1, 9);
        run_lat(2, 1'b0, 7);
        run_lat(8, 1'b1, 39);
        run_lat(8, 1'b0, 31);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
